// File: rtl/vga_text_console.sv
// Byte-stream console writer for the VGA text display: decodes CR/LF/FF/BS,
// tracks a cursor and drives the text-buffer write port one cell per Latch.
module vga_text_console #(
  parameter int unsigned LINES       = 30,
  parameter int unsigned COLUMNS     = 80,
  parameter logic [7:0]  BLANK_GLYPH = 8'h20
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_data,
  input  logic [11:0] i_data_fg,
  input  logic [11:0] i_data_bg,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [4:0]  o_line,
  output logic [6:0]  o_character,
  output logic [7:0]  o_glyph,
  output logic [11:0] o_foreground,
  output logic [11:0] o_background,
  output logic        o_latch,
  output logic [4:0]  o_cursor_line,
  output logic [6:0]  o_cursor_character
);

  localparam int unsigned LINE_W = 5;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned DATA_W = 8;

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLUMNS - 1);

  localparam logic [DATA_W-1:0] CH_BS = 8'h08;
  localparam logic [DATA_W-1:0] CH_LF = 8'h0A;
  localparam logic [DATA_W-1:0] CH_FF = 8'h0C;
  localparam logic [DATA_W-1:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    S_CLR_SCREEN = 2'd0,
    S_IDLE       = 2'd1,
    S_CLR_LINE   = 2'd2
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic [LINE_W-1:0]   r_scan_line, w_scan_line_nxt;
  logic [COL_W-1:0]    r_scan_col,  w_scan_col_nxt;
  logic [LINE_W-1:0]   r_cur_line,  w_cur_line_nxt;
  logic [COL_W-1:0]    r_cur_col,   w_cur_col_nxt;
  logic [RGB_W-1:0]    r_clr,       w_clr_nxt;
  logic                r_ready,     w_ready_nxt;
  logic                r_latch,     w_latch_nxt;
  logic [LINE_W-1:0]   r_line,      w_line_nxt;
  logic [COL_W-1:0]    r_char,      w_char_nxt;
  logic [DATA_W-1:0]   r_glyph,     w_glyph_nxt;
  logic [RGB_W-1:0]    r_fg,        w_fg_nxt;
  logic [RGB_W-1:0]    r_bg,        w_bg_nxt;
  logic                w_xfer;
  logic [LINE_W-1:0]   w_next_line;

  // State and registered write-port outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_CLR_SCREEN;
      r_scan_line <= '0;
      r_scan_col  <= '0;
      r_cur_line  <= '0;
      r_cur_col   <= '0;
      r_clr       <= '0;
      r_ready     <= 1'b0;
      r_latch     <= 1'b0;
      r_line      <= '0;
      r_char      <= '0;
      r_glyph     <= '0;
      r_fg        <= '0;
      r_bg        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_scan_line <= w_scan_line_nxt;
      r_scan_col  <= w_scan_col_nxt;
      r_cur_line  <= w_cur_line_nxt;
      r_cur_col   <= w_cur_col_nxt;
      r_clr       <= w_clr_nxt;
      r_ready     <= w_ready_nxt;
      r_latch     <= w_latch_nxt;
      r_line      <= w_line_nxt;
      r_char      <= w_char_nxt;
      r_glyph     <= w_glyph_nxt;
      r_fg        <= w_fg_nxt;
      r_bg        <= w_bg_nxt;
    end
  end

  assign w_xfer      = i_valid && r_ready && (r_state == S_IDLE);
  assign w_next_line = (r_cur_line == LAST_LINE) ? '0 : r_cur_line + LINE_W'(1);

  // Next-state, cursor and write-port decode
  always_comb begin
    w_state_nxt     = r_state;
    w_scan_line_nxt = r_scan_line;
    w_scan_col_nxt  = r_scan_col;
    w_cur_line_nxt  = r_cur_line;
    w_cur_col_nxt   = r_cur_col;
    w_clr_nxt       = r_clr;
    w_ready_nxt     = r_ready;
    w_latch_nxt     = 1'b0;
    w_line_nxt      = r_line;
    w_char_nxt      = r_char;
    w_glyph_nxt     = r_glyph;
    w_fg_nxt        = r_fg;
    w_bg_nxt        = r_bg;

    case (r_state)
      S_CLR_SCREEN: begin
        w_ready_nxt = 1'b0;
        w_latch_nxt = 1'b1;
        w_line_nxt  = r_scan_line;
        w_char_nxt  = r_scan_col;
        w_glyph_nxt = BLANK_GLYPH;
        w_fg_nxt    = r_clr;
        w_bg_nxt    = r_clr;
        if (r_scan_col == LAST_COL) begin
          w_scan_col_nxt = '0;
          if (r_scan_line == LAST_LINE) begin
            w_scan_line_nxt = '0;
            w_state_nxt     = S_IDLE;
            w_ready_nxt     = 1'b1;
            w_cur_line_nxt  = '0;
            w_cur_col_nxt   = '0;
          end else begin
            w_scan_line_nxt = r_scan_line + LINE_W'(1);
          end
        end else begin
          w_scan_col_nxt = r_scan_col + COL_W'(1);
        end
      end

      S_CLR_LINE: begin
        w_ready_nxt = 1'b0;
        w_latch_nxt = 1'b1;
        w_line_nxt  = r_cur_line;
        w_char_nxt  = r_scan_col;
        w_glyph_nxt = BLANK_GLYPH;
        w_fg_nxt    = r_clr;
        w_bg_nxt    = r_clr;
        if (r_scan_col == LAST_COL) begin
          w_scan_col_nxt = '0;
          w_state_nxt    = S_IDLE;
          w_ready_nxt    = 1'b1;
        end else begin
          w_scan_col_nxt = r_scan_col + COL_W'(1);
        end
      end

      S_IDLE: begin
        w_ready_nxt = 1'b1;
        if (w_xfer) begin
          case (i_data)
            CH_CR: w_cur_col_nxt = '0;
            CH_LF: begin
              w_cur_line_nxt = w_next_line;
              w_clr_nxt      = i_data_bg;
              w_scan_col_nxt = '0;
              w_state_nxt    = S_CLR_LINE;
              w_ready_nxt    = 1'b0;
            end
            CH_FF: begin
              w_clr_nxt       = i_data_bg;
              w_scan_line_nxt = '0;
              w_scan_col_nxt  = '0;
              w_cur_line_nxt  = '0;
              w_cur_col_nxt   = '0;
              w_state_nxt     = S_CLR_SCREEN;
              w_ready_nxt     = 1'b0;
            end
            CH_BS: begin
              if (r_cur_col != '0) begin
                w_cur_col_nxt = r_cur_col - COL_W'(1);
                w_latch_nxt   = 1'b1;
                w_line_nxt    = r_cur_line;
                w_char_nxt    = r_cur_col - COL_W'(1);
                w_glyph_nxt   = BLANK_GLYPH;
                w_fg_nxt      = i_data_fg;
                w_bg_nxt      = i_data_bg;
              end
            end
            default: begin
              w_latch_nxt = 1'b1;
              w_line_nxt  = r_cur_line;
              w_char_nxt  = r_cur_col;
              w_glyph_nxt = i_data;
              w_fg_nxt    = i_data_fg;
              w_bg_nxt    = i_data_bg;
              // Writing the last column wraps and clears the following line
              if (r_cur_col == LAST_COL) begin
                w_cur_col_nxt  = '0;
                w_cur_line_nxt = w_next_line;
                w_clr_nxt      = i_data_bg;
                w_scan_col_nxt = '0;
                w_state_nxt    = S_CLR_LINE;
                w_ready_nxt    = 1'b0;
              end else begin
                w_cur_col_nxt = r_cur_col + COL_W'(1);
              end
            end
          endcase
        end
      end

      default: begin
        w_state_nxt     = S_CLR_SCREEN;
        w_scan_line_nxt = '0;
        w_scan_col_nxt  = '0;
        w_ready_nxt     = 1'b0;
      end
    endcase
  end

  assign o_ready            = r_ready;
  assign o_latch            = r_latch;
  assign o_line             = r_line;
  assign o_character        = r_char;
  assign o_glyph            = r_glyph;
  assign o_foreground       = r_fg;
  assign o_background       = r_bg;
  assign o_cursor_line      = r_cur_line;
  assign o_cursor_character = r_cur_col;

endmodule

// File: tb/tb_vga_text_console.sv
// Scoreboard bench for vga_text_console: a console model pushes expected cell
// writes, a negedge monitor pops and compares them on every Latch.
module tb_vga_text_console;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i_data;
  logic [11:0] i_fg, i_bg;
  logic        i_valid;
  logic        o_ready, o_latch;
  logic [4:0]  o_line, o_cursor_line;
  logic [6:0]  o_character, o_cursor_character;
  logic [7:0]  o_glyph;
  logic [11:0] o_foreground, o_background;

  int vectors    = 0;
  int miscompares = 0;
  int lat_cnt    = 0;

  logic [43:0] exp_q[$];
  logic [43:0] m_got, m_want;
  logic [4:0]  e_line;
  logic [6:0]  e_col;
  logic [11:0] e_clr;

  always #5 clk = ~clk;

  vga_text_console dut (
    .i_clk              (clk),
    .i_reset_n          (rst_n),
    .i_data             (i_data),
    .i_data_fg          (i_fg),
    .i_data_bg          (i_bg),
    .i_valid            (i_valid),
    .o_ready            (o_ready),
    .o_line             (o_line),
    .o_character        (o_character),
    .o_glyph            (o_glyph),
    .o_foreground       (o_foreground),
    .o_background       (o_background),
    .o_latch            (o_latch),
    .o_cursor_line      (o_cursor_line),
    .o_cursor_character (o_cursor_character)
  );

  // Every Latch must match the next expected cell write
  always @(negedge clk) begin
    if (o_latch === 1'b1) begin
      lat_cnt++;
      vectors++;
      m_got = {o_line, o_character, o_glyph, o_foreground, o_background};
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_latch got line=%0d col=%0d glyph=%h fg=%h bg=%h required no write",
                 o_line, o_character, o_glyph, o_foreground, o_background);
      end else begin
        m_want = exp_q.pop_front();
        if (m_got !== m_want) begin
          miscompares++;
          $display("FAIL cell_write got line=%0d col=%0d glyph=%h fg=%h bg=%h required line=%0d col=%0d glyph=%h fg=%h bg=%h",
                   m_got[43:39], m_got[38:32], m_got[31:24], m_got[23:12], m_got[11:0],
                   m_want[43:39], m_want[38:32], m_want[31:24], m_want[23:12], m_want[11:0]);
        end
      end
    end
  end

  function automatic logic [4:0] wrap_line(input logic [4:0] l);
    return (l == 5'd29) ? 5'd0 : l + 5'd1;
  endfunction

  task automatic push_cell(input logic [4:0] l, input logic [6:0] c, input logic [7:0] g,
                           input logic [11:0] fg, input logic [11:0] bg);
    exp_q.push_back({l, c, g, fg, bg});
  endtask

  task automatic push_line_clear(input logic [4:0] l, input logic [11:0] clr);
    for (int c = 0; c < 80; c++) push_cell(l, 7'(c), 8'h20, clr, clr);
  endtask

  task automatic push_screen_clear(input logic [11:0] clr);
    for (int l = 0; l < 30; l++) push_line_clear(5'(l), clr);
  endtask

  // Console model applied at the transfer edge
  task automatic model_xfer(input logic [7:0] d, input logic [11:0] fg, input logic [11:0] bg);
    case (d)
      8'h0D: e_col = 7'd0;
      8'h0A: begin
        e_line = wrap_line(e_line);
        e_clr  = bg;
        push_line_clear(e_line, e_clr);
      end
      8'h0C: begin
        e_clr = bg; e_line = 5'd0; e_col = 7'd0;
        push_screen_clear(e_clr);
      end
      8'h08: begin
        if (e_col != 7'd0) begin
          e_col = e_col - 7'd1;
          push_cell(e_line, e_col, 8'h20, fg, bg);
        end
      end
      default: begin
        push_cell(e_line, e_col, d, fg, bg);
        if (e_col == 7'd79) begin
          e_col  = 7'd0;
          e_line = wrap_line(e_line);
          e_clr  = bg;
          push_line_clear(e_line, e_clr);
        end else begin
          e_col = e_col + 7'd1;
        end
      end
    endcase
  endtask

  // Waits for Ready (valid low meanwhile), then transfers one byte
  task automatic send_byte(input logic [7:0] d, input logic [11:0] fg, input logic [11:0] bg);
    int w = 0;
    @(negedge clk);
    while (o_ready !== 1'b1 && w < 4000) begin
      i_valid = 1'b0;
      w++;
      @(negedge clk);
    end
    if (o_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout got ready=%b required 1 within 4000 cycles", o_ready);
    end else begin
      i_valid = 1'b1; i_data = d; i_fg = fg; i_bg = bg;
      @(posedge clk);
      model_xfer(d, fg, bg);
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // Counts negedges (starting with the current one) on which Ready is low
  task automatic count_not_ready(output int n);
    n = 0;
    while (o_ready !== 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic reset_and_clear(input string tag);
    int n, base;
    @(negedge clk);
    rst_n = 1'b0; i_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({o_ready, o_latch, o_line, o_character, o_glyph, o_foreground, o_background} !== 51'd0) begin
      miscompares++;
      $display("FAIL %s_reset_outputs got ready=%b latch=%b line=%0d col=%0d glyph=%h fg=%h bg=%h required all 0",
               tag, o_ready, o_latch, o_line, o_character, o_glyph, o_foreground, o_background);
    end
    vectors++;
    if ({o_cursor_line, o_cursor_character} !== 12'd0) begin
      miscompares++;
      $display("FAIL %s_reset_cursor got (%0d,%0d) required (0,0)", tag, o_cursor_line, o_cursor_character);
    end
    exp_q.delete();
    e_line = 5'd0; e_col = 7'd0; e_clr = 12'h000;
    push_screen_clear(12'h000);
    base  = lat_cnt;
    rst_n = 1'b1;
    count_not_ready(n);
    vectors++;
    if (n != 2400) begin
      miscompares++;
      $display("FAIL %s_clear_ready_low got %0d cycles required 2400", tag, n);
    end
    @(negedge clk);
    vectors++;
    if (lat_cnt - base != 2400 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_clear_writes got %0d latches (%0d pending) required 2400 (0 pending)",
               tag, lat_cnt - base, exp_q.size());
    end
    vectors++;
    if (o_ready !== 1'b1 || {o_cursor_line, o_cursor_character} !== 12'd0) begin
      miscompares++;
      $display("FAIL %s_after_clear got ready=%b cursor=(%0d,%0d) required ready=1 cursor=(0,0)",
               tag, o_ready, o_cursor_line, o_cursor_character);
    end
  endtask

  task automatic test_reset();
    reset_and_clear("por");
  endtask

  task automatic test_back_to_back();
    int base;
    base = lat_cnt;
    send_byte(8'h41, 12'hFFF, 12'h00F);
    send_byte(8'h42, 12'hFFF, 12'h00F);
    idle_in();
    vectors++;
    if (o_latch !== 1'b1 || o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second_write got latch=%b ready=%b required latch=1 ready=1", o_latch, o_ready);
    end
    vectors++;
    if ({o_cursor_line, o_cursor_character} !== {5'd0, 7'd2}) begin
      miscompares++;
      $display("FAIL b2b_cursor got (%0d,%0d) required (0,2)", o_cursor_line, o_cursor_character);
    end
    @(negedge clk);
    vectors++;
    if (lat_cnt - base != 2 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_latch_count got %0d (%0d pending) required 2 (0 pending)", lat_cnt - base, exp_q.size());
    end
  endtask

  task automatic test_line_wrap();
    int n;
    send_byte(8'h0D, 12'h000, 12'h000);
    for (int i = 0; i < 5; i++) send_byte(8'h0A, 12'h000, 12'h0A0);
    for (int i = 0; i < 80; i++)
      send_byte(8'h41 + 8'(i % 26), 12'(i * 37), 12'(i * 13 + 1));
    idle_in();
    vectors++;
    if ({o_cursor_line, o_cursor_character} !== {5'd6, 7'd0}) begin
      miscompares++;
      $display("FAIL wrap_cursor got (%0d,%0d) required (6,0)", o_cursor_line, o_cursor_character);
    end
    count_not_ready(n);
    vectors++;
    if (n != 80) begin
      miscompares++;
      $display("FAIL wrap_ready_low got %0d cycles required 80", n);
    end
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_pending got %0d writes outstanding required 0", exp_q.size());
    end
  endtask

  task automatic test_cr_lf_wrap();
    int n, base;
    for (int i = 0; i < 23; i++) send_byte(8'h0A, 12'h000, 12'h321);
    for (int i = 0; i < 3; i++) send_byte(8'h61 + 8'(i), 12'h0F0, 12'h010);
    idle_in();
    @(negedge clk);
    base = lat_cnt;
    send_byte(8'h0D, 12'h000, 12'h000);
    idle_in();
    repeat (2) @(negedge clk);
    vectors++;
    if (lat_cnt != base || {o_cursor_line, o_cursor_character} !== {5'd29, 7'd0}) begin
      miscompares++;
      $display("FAIL cr_no_write got %0d latches cursor=(%0d,%0d) required 0 latches cursor=(29,0)",
               lat_cnt - base, o_cursor_line, o_cursor_character);
    end
    send_byte(8'h0A, 12'h000, 12'h5A5);
    idle_in();
    vectors++;
    if ({o_cursor_line, o_cursor_character} !== 12'd0) begin
      miscompares++;
      $display("FAIL lf_wrap_cursor got (%0d,%0d) required (0,0)", o_cursor_line, o_cursor_character);
    end
    count_not_ready(n);
    @(negedge clk);
    vectors++;
    if (n != 80 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL lf_wrap_clear got %0d busy cycles (%0d pending) required 80 (0 pending)", n, exp_q.size());
    end
  endtask

  task automatic test_backspace();
    int n, base;
    send_byte(8'h0A, 12'h000, 12'h000);
    send_byte(8'h0A, 12'h000, 12'h000);
    idle_in();
    count_not_ready(n);
    @(negedge clk);
    base = lat_cnt;
    send_byte(8'h08, 12'hABC, 12'h123);
    idle_in();
    @(negedge clk);
    vectors++;
    if (lat_cnt != base || {o_cursor_line, o_cursor_character} !== {5'd2, 7'd0}) begin
      miscompares++;
      $display("FAIL bs_col0 got %0d latches cursor=(%0d,%0d) required 0 latches cursor=(2,0)",
               lat_cnt - base, o_cursor_line, o_cursor_character);
    end
    for (int i = 0; i < 7; i++) send_byte(8'h30 + 8'(i), 12'h777, 12'h111);
    idle_in();
    @(negedge clk);
    base = lat_cnt;
    send_byte(8'h08, 12'hABC, 12'h123);
    idle_in();
    vectors++;
    if (o_latch !== 1'b1) begin
      miscompares++;
      $display("FAIL bs_latency got latch=%b required 1", o_latch);
    end
    @(negedge clk);
    vectors++;
    if (lat_cnt - base != 1 || exp_q.size() != 0 || {o_cursor_line, o_cursor_character} !== {5'd2, 7'd6}) begin
      miscompares++;
      $display("FAIL bs_erase got %0d latches (%0d pending) cursor=(%0d,%0d) required 1 latch (0 pending) cursor=(2,6)",
               lat_cnt - base, exp_q.size(), o_cursor_line, o_cursor_character);
    end
  endtask

  task automatic test_ff_reset_abort();
    int k = 0, w = 0;
    send_byte(8'h0C, 12'h000, 12'hF00);
    @(negedge clk);
    i_valid = 1'b0;
    while (w < 500) begin
      if (o_latch === 1'b1) k++;
      if (k == 100) break;
      w++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    vectors++;
    if (k != 100) begin
      miscompares++;
      $display("FAIL ff_clear_progress got %0d writes required 100", k);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (o_latch !== 1'b0 || o_ready !== 1'b0 || exp_q.size() != 2300) begin
      miscompares++;
      $display("FAIL ff_abort got latch=%b ready=%b pending=%0d required latch=0 ready=0 pending=2300",
               o_latch, o_ready, exp_q.size());
    end
    reset_and_clear("abort");
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_fg = '0; i_bg = '0;
    e_line = '0; e_col = '0; e_clr = '0;
    test_reset();
    test_back_to_back();
    test_line_wrap();
    test_cr_lf_wrap();
    test_backspace();
    test_ff_reset_abort();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_text_console.md
Name: vga_text_console

Overview:
- Byte-stream console writer that sits directly upstream of the VGA text display block.
- Accepts character codes over a valid/ready handshake and tracks a cursor.
- Interprets a small set of control codes and drives the display's text-buffer write port (Line, Character, Glyph, Foreground, Background, Latch), one cell per Latch pulse.
- Clears the screen itself after reset and when a form-feed is received.

Parameters:
- LINES, 30, visible text rows (480/16); cursor line wraps at LINES-1.
- COLUMNS, 80, visible text columns (640/8); cursor column wraps at COLUMNS-1.
- BLANK_GLYPH, 8'h20, glyph index written when clearing cells.

Ports:
- Clk  input  1  interface clock; same clock as the display's write port.
- Reset  input  1  synchronous, active-low reset.
- Data  input  8  character code / glyph index.
- Data_Fg  input  12  foreground RGB (4:4:4); sampled with Data.
- Data_Bg  input  12  background RGB (4:4:4); sampled with Data, also used for clears.
- Valid  input  1  Data/Data_Fg/Data_Bg valid.
- Ready  output  1  block can accept; a transfer occurs when Valid && Ready on a Clk edge.
- Line  output  5  text-buffer write row.
- Character  output  7  text-buffer write column.
- Glyph  output  8  glyph written.
- Foreground  output  12  foreground written.
- Background  output  12  background written.
- Latch  output  1  one-cycle write strobe to the text buffer.
- Cursor_Line  output  5  current cursor row.
- Cursor_Character  output  7  current cursor column.

Behaviour:
- Reset (Reset==0 at a Clk edge):
  - Line=0, Character=0, Glyph=0, Foreground=0, Background=0, Latch=0, Ready=0.
  - Cursor=(0,0); clear colour=12'h000.
  - State goes to CLR_SCREEN with scan counter at (0,0).
  - Reset mid-clear abandons the clear and restarts it from (0,0).
- States:
  - CLR_SCREEN: one cell per cycle, Latch=1, Glyph=BLANK_GLYPH, Background=clear colour, Foreground=clear colour. Order is column 0..COLUMNS-1, then the next line, through LINES*COLUMNS cells (2400 cycles). Then enter IDLE with cursor=(0,0).
  - IDLE: Ready=1, Latch=0 unless a write is being issued.
  - CLR_LINE: one cell per cycle across Cursor_Line, columns 0..COLUMNS-1 (80 cycles), with Latch=1 and clear colour. Then IDLE.
- Ready is 1 only in IDLE and never in the cycle a transfer is decoded into a clear; Ready=0 throughout CLR_SCREEN and CLR_LINE.
- On a transfer in IDLE, by Data value:
  - 8'h0D (CR): cursor column←0; no write.
  - 8'h0A (LF):
    - cursor line←(line==LINES-1)?0:line+1; column unchanged.
    - clear colour←Data_Bg; enter CLR_LINE on the new line.
  - 8'h0C (FF): clear colour←Data_Bg; enter CLR_SCREEN; cursor←(0,0).
  - 8'h08 (BS):
    - If column>0: column←column-1, then write BLANK_GLYPH with Data_Fg/Data_Bg at the new position.
    - At column 0: no change, no write.
  - Any other value (printable):
    - Write Data at the cursor with Data_Fg/Data_Bg; the registered outputs appear with Latch=1 in the cycle after the transfer edge (1-cycle latency).
    - Then advance the column.
    - If the column was COLUMNS-1: column←0, line advances with the same wrap as LF, clear colour←Data_Bg, enter CLR_LINE for the new line. Ready is 0 the cycle after the transfer, and the CLR_LINE writes follow the glyph write back-to-back.
- Back-to-back printable transfers in IDLE are sustained at 1 per cycle; each produces exactly one Latch.
- Latch is never high for more than one cycle per cell.
- Line/Character/Glyph/Foreground/Background hold their last value when Latch=0.
- Cursor_* outputs update on the same edge as the cursor change.
- No scrolling: the cursor wraps from line LINES-1 to line 0, and that line is cleared.
- Widths:
  - Cursor and scan counters saturate-compare against LINES-1/COLUMNS-1, never against their full width.
  - Values never reach 30..31 (line) or 80..127 (column).

Test Plan:
- Reset low 3 cycles, then high → Ready=0 for exactly 2400 cycles with 2400 Latch pulses. First write is (0,0), last is (29,79), all Glyph=8'h20, colour 12'h000. Ready=1 on the next cycle; cursor=(0,0).
- Stream "AB" (8'h41, 8'h42), Fg=12'hFFF, Bg=12'h00F, Valid held → Latch on consecutive cycles writing (0,0)=41 and (0,1)=42. Cursor becomes (0,2); Ready stays 1.
- 80 printable bytes from (5,0) → the 80th writes (5,79). Cursor becomes (6,0). Ready=0 for 80 cycles while (6,0)..(6,79) are written with 8'h20 and the last Bg. Then Ready=1.
- Cursor at (29,3), send 8'h0D then 8'h0A → the CR produces no Latch and gives cursor (29,0). The LF gives cursor (0,0) and 80 clear writes on line 0.
- Cursor (2,0) send 8'h08 → no Latch, cursor unchanged. Cursor (2,7) send 8'h08 → one write of 8'h20 at (2,6); cursor (2,6).
- Send 8'h0C with Bg=12'hF00, then drop Reset low after 100 clear writes → clear aborts. A full 2400-cycle clear restarts with colour 12'h000 once Reset goes high.
